factorial_ctrl: RTL and testbench

FACTORIAL_CTRL -- requirements
Module: factorial_ctrl

---
 rtl/factorial_ctrl_if.sv | 28 ++
 rtl/factorial_ctrl.sv | 171 +++++++++++++++++
 tb/tb_factorial_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/factorial_ctrl_if.sv
// Handshake and register-file bus between the factorial controller and its environment.
interface factorial_ctrl_if;
  logic        start;
  logic [3:0]  n_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        rf_we;
  logic [1:0]  rf_raddr1;
  logic [1:0]  rf_raddr2;
  logic [1:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;

  modport slave (
    input  start, n_in, rf_rdata1, rf_rdata2,
    output busy, done, result, overflow,
    output rf_we, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata
  );

  modport master (
    output start, n_in, rf_rdata1, rf_rdata2,
    input  busy, done, result, overflow,
    input  rf_we, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/factorial_ctrl.sv
// Iterative n! controller: counter in R0, accumulator in R1 of an external register file,
// with a 4-cycle shift-add multiplier for each acc*i step.
module factorial_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  factorial_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_ACC, S_INIT_CNT, S_CHECK, S_MUL, S_WB, S_DEC, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] mcand_q, mcand_d;
  logic [3:0]  mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  logic [1:0]  bit_cnt_q, bit_cnt_d;

  logic        rf_we_s;
  logic [1:0]  rf_raddr1_s, rf_raddr2_s, rf_waddr_s;
  logic [31:0] rf_wdata_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      ovf_q     <= 1'b0;
      n_q       <= 4'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 4'd0;
      prod_q    <= 32'd0;
      bit_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      n_q       <= n_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state, datapath updates and register-file strobes
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    ovf_d       = ovf_q;
    n_d         = n_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    bit_cnt_d   = bit_cnt_q;
    rf_we_s     = 1'b0;
    rf_raddr1_s = 2'd0;
    rf_raddr2_s = 2'd0;
    rf_waddr_s  = 2'd0;
    rf_wdata_s  = 32'd0;

    case (state_q)
      S_IDLE: begin
        // The done cycle is spent in IDLE, but a start there must still be ignored
        if (bus.start && !done_q) begin
          result_d = 32'd0;
          busy_d   = 1'b1;
          if (bus.n_in > 4'd12) begin
            ovf_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            ovf_d   = 1'b0;
            n_d     = bus.n_in;
            state_d = S_INIT_ACC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT_ACC: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = 2'd1;
        rf_wdata_s = 32'd1;
        state_d    = S_INIT_CNT;
      end
      S_INIT_CNT: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = 2'd0;
        rf_wdata_s = {28'd0, n_q};
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        rf_raddr1_s = 2'd1;
        rf_raddr2_s = 2'd0;
        if (bus.rf_rdata2 <= 32'd1) begin
          state_d = S_FINISH;
        end else begin
          mcand_d   = bus.rf_rdata1;
          mplier_d  = bus.rf_rdata2[3:0];
          prod_d    = 32'd0;
          bit_cnt_d = 2'd0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end else begin
          prod_d = prod_q;
        end
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) begin
          state_d = S_WB;
        end else begin
          state_d = S_MUL;
        end
      end
      S_WB: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = 2'd1;
        rf_wdata_s = prod_q;
        state_d    = S_DEC;
      end
      S_DEC: begin
        rf_raddr2_s = 2'd0;
        rf_we_s     = 1'b1;
        rf_waddr_s  = 2'd0;
        rf_wdata_s  = bus.rf_rdata2 - 32'd1;
        state_d     = S_CHECK;
      end
      S_FINISH: begin
        rf_raddr1_s = 2'd1;
        if (ovf_q) begin
          result_d = 32'd0;
        end else begin
          result_d = bus.rf_rdata1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.rf_we     = rf_we_s;
  assign bus.rf_raddr1 = rf_raddr1_s;
  assign bus.rf_raddr2 = rf_raddr2_s;
  assign bus.rf_waddr  = rf_waddr_s;
  assign bus.rf_wdata  = rf_wdata_s;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl: directed table, reset/noise sequences and random operands.
module tb_factorial_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  factorial_ctrl_if ifc ();

  factorial_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational reads, write lands on the rising edge
  logic [31:0] rf [4];
  assign ifc.rf_rdata1 = rf[ifc.rf_raddr1];
  assign ifc.rf_rdata2 = rf[ifc.rf_raddr2];

  always @(posedge clk) begin
    if (ifc.rf_we) rf[ifc.rf_waddr] <= ifc.rf_wdata;
  end

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];

  // Record every write strobe once, mid-cycle
  always @(negedge clk) begin
    if (rst_n && ifc.rf_we) wq.push_back('{a: ifc.rf_waddr, d: ifc.rf_wdata});
  end

  typedef struct {
    logic [3:0]  n;
    logic [31:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;
    logic        noise;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_fact(input int n);
    longint acc;
    acc = 1;
    for (int k = 2; k <= n; k++) acc = acc * k;
    return (n > 12) ? 32'd0 : acc[31:0];
  endfunction

  function automatic int model_lat(input int n);
    if (n > 12) return 1;
    if (n <= 1) return 4;
    return 7 * n - 3;
  endfunction

  // Expected register-file write trace: init R1, R0, then (acc, i-1) for i = n down to 2
  task automatic model_writes(input int n, output wr_t q[$]);
    longint acc;
    q.delete();
    if (n <= 12) begin
      q.push_back('{a: 2'd1, d: 32'd1});
      q.push_back('{a: 2'd0, d: 32'(n)});
      acc = 1;
      for (int i = n; i >= 2; i--) begin
        acc = acc * i;
        q.push_back('{a: 2'd1, d: acc[31:0]});
        q.push_back('{a: 2'd0, d: 32'(i - 1)});
      end
    end
  endtask

  // Caller is just past an active edge; the next edge accepts the start (E0)
  task automatic run_op(input logic [3:0] n, input logic [31:0] exp_res, input logic exp_ovf,
                        input int exp_lat, input logic noise, input string tag);
    int  cyc;
    int  busy_drops;
    logic seen;
    wr_t exp_q[$];
    wq.delete();
    ifc.n_in  = n;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start  = noise;
    ifc.n_in   = noise ? 4'd9 : 4'd0;
    cyc        = 0;
    busy_drops = 0;
    seen       = 1'b0;
    chk({tag, "_busy_e0"}, 32'(ifc.busy), 32'd1);
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (ifc.done) seen = 1'b1;
      else if (!ifc.busy) busy_drops++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_held"}, 32'(busy_drops), 32'd0);
    chk({tag, "_result"}, ifc.result, exp_res);
    chk({tag, "_overflow"}, 32'(ifc.overflow), 32'(exp_ovf));
    chk({tag, "_busy_at_done"}, 32'(ifc.busy), 32'd0);
    // Start (if noisy) is still high across the done cycle and must be ignored
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.n_in  = 4'd0;
    chk({tag, "_done_pulse"}, 32'(ifc.done), 32'd0);
    chk({tag, "_idle_after"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_result_held"}, ifc.result, exp_res);
    model_writes(int'(n), exp_q);
    chk({tag, "_wr_count"}, 32'(wq.size()), 32'(exp_q.size()));
    if (wq.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        chk({tag, "_wr_addr"}, 32'(wq[i].a), 32'(exp_q[i].a));
        chk({tag, "_wr_data"}, wq[i].d, exp_q[i].d);
      end
    end
  endtask

  vec_t tbl[$];
  logic [3:0] rn;
  logic       rnoise;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.n_in  = 4'd0;
    #1;
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_result", ifc.result, 32'd0);
    chk("rst_overflow", 32'(ifc.overflow), 32'd0);
    chk("rst_rf_we", 32'(ifc.rf_we), 32'd0);
    chk("rst_rf_bus", {ifc.rf_raddr1, ifc.rf_raddr2, ifc.rf_waddr} | ifc.rf_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    tbl.push_back('{n: 4'd5,  exp_res: 32'd120,        exp_ovf: 1'b0, exp_lat: 32, noise: 1'b0});
    tbl.push_back('{n: 4'd0,  exp_res: 32'd1,          exp_ovf: 1'b0, exp_lat: 4,  noise: 1'b0});
    tbl.push_back('{n: 4'd1,  exp_res: 32'd1,          exp_ovf: 1'b0, exp_lat: 4,  noise: 1'b0});
    tbl.push_back('{n: 4'd12, exp_res: 32'h1C8C_FC00,  exp_ovf: 1'b0, exp_lat: 81, noise: 1'b0});
    tbl.push_back('{n: 4'd13, exp_res: 32'd0,          exp_ovf: 1'b1, exp_lat: 1,  noise: 1'b0});
    tbl.push_back('{n: 4'd2,  exp_res: 32'd2,          exp_ovf: 1'b0, exp_lat: 11, noise: 1'b0});
    tbl.push_back('{n: 4'd15, exp_res: 32'd0,          exp_ovf: 1'b1, exp_lat: 1,  noise: 1'b0});
    tbl.push_back('{n: 4'd4,  exp_res: 32'd24,         exp_ovf: 1'b0, exp_lat: 25, noise: 1'b1});
    tbl.push_back('{n: 4'd3,  exp_res: 32'd6,          exp_ovf: 1'b0, exp_lat: 18, noise: 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].n, tbl[i].exp_res, tbl[i].exp_ovf, tbl[i].exp_lat, tbl[i].noise,
             $sformatf("vec%0d_n%0d", i, tbl[i].n));
    end

    // Reset in the middle of an n=7 run, then restart on the first edge after release
    ifc.n_in  = 4'd7;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.n_in  = 4'd0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 32'(ifc.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
    chk("mid_rst_done", 32'(ifc.done), 32'd0);
    chk("mid_rst_result", ifc.result, 32'd0);
    chk("mid_rst_overflow", 32'(ifc.overflow), 32'd0);
    chk("mid_rst_rf_we", 32'(ifc.rf_we), 32'd0);
    chk("mid_rst_rf_bus", {ifc.rf_raddr1, ifc.rf_raddr2, ifc.rf_waddr} | ifc.rf_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(4'd3, 32'd6, 1'b0, 18, 1'b0, "post_rst_n3");

    for (int i = 0; i < 20; i++) begin
      rn     = 4'($urandom_range(0, 15));
      rnoise = ($urandom_range(0, 3) == 0);
      run_op(rn, model_fact(int'(rn)), (rn > 4'd12), model_lat(int'(rn)), rnoise,
             $sformatf("rand%0d_n%0d", i, rn));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
